// File: rtl/multi_zone_thermostat.sv
// Multi-zone thermostat: debounced setpoint buttons, per-zone temperature
// registers with staleness tracking, and a hysteretic heat/cool FSM per zone.
module multi_zone_thermostat #(
  parameter int NUM_ZONES       = 4,
  parameter int TEMP_W          = 8,
  parameter int SP_DEFAULT      = 25,
  parameter int SP_MIN          = 16,
  parameter int SP_MAX          = 32,
  parameter int HYST            = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 30000000,
  parameter int STALE_CYCLES    = 300000000,
  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 mode_switch,
  input  logic [ZW-1:0]        zone_sel,
  input  logic                 temp_valid,
  input  logic [ZW-1:0]        temp_zone,
  input  logic [TEMP_W-1:0]    temp_in,
  output logic [TEMP_W-1:0]    display_temp,
  output logic [NUM_ZONES-1:0] heat_on,
  output logic [NUM_ZONES-1:0] cool_on,
  output logic [NUM_ZONES-1:0] zone_fault,
  output logic                 sp_at_limit
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);
  localparam int STW = $clog2(STALE_CYCLES + 1);

  localparam logic [DBW-1:0]    DB_MAX  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0]    REP_MAX = RPW'(REPEAT_CYCLES);
  localparam logic [STW-1:0]    ST_MAX  = STW'(STALE_CYCLES);
  localparam logic [TEMP_W-1:0] SPDEF   = TEMP_W'(SP_DEFAULT);
  localparam logic [TEMP_W-1:0] SPMIN   = TEMP_W'(SP_MIN);
  localparam logic [TEMP_W-1:0] SPMAX   = TEMP_W'(SP_MAX);
  localparam logic [TEMP_W:0]   HYS     = (TEMP_W + 1)'(HYST);
  localparam logic [ZW:0]       NZ      = (ZW + 1)'(NUM_ZONES);

  typedef enum logic [1:0] {
    S_FAULT,
    S_IDLE,
    S_HEAT,
    S_COOL
  } state_t;

  // bit 0 = up, bit 1 = down
  logic [1:0]     r_s1;
  logic [1:0]     r_s2;
  logic [1:0]     r_db;
  logic [1:0]     r_db_d;
  logic [DBW-1:0] r_dcnt [2];
  logic [RPW-1:0] r_rep  [2];
  logic           w_both;
  logic [1:0]     w_step;

  logic [TEMP_W-1:0] r_sp    [NUM_ZONES];
  logic [TEMP_W-1:0] r_temp  [NUM_ZONES];
  logic [STW-1:0]    r_stale [NUM_ZONES];
  state_t            r_st    [NUM_ZONES];
  state_t            w_nx    [NUM_ZONES];
  logic [TEMP_W:0]   w_t     [NUM_ZONES];
  logic [TEMP_W:0]   w_s     [NUM_ZONES];

  logic [NUM_ZONES-1:0] w_acc;
  logic                 w_sel_ok;
  logic                 w_zone_ok;
  logic [TEMP_W-1:0]    r_disp;
  logic                 r_lim;

  assign w_both    = r_db[0] & r_db[1];
  assign w_sel_ok  = {1'b0, zone_sel} < NZ;
  assign w_zone_ok = {1'b0, temp_zone} < NZ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db   <= '0;
      r_db_d <= '0;
      for (int b = 0; b < 2; b++) begin
        r_dcnt[b] <= '0;
        r_rep[b]  <= '0;
      end
    end else begin
      r_s1   <= {btn_down, btn_up};
      r_s2   <= r_s1;
      r_db_d <= r_db;
      for (int b = 0; b < 2; b++) begin
        if (r_s2[b] == r_db[b]) begin
          r_dcnt[b] <= '0;
        end else if (r_dcnt[b] == DB_MAX) begin
          r_db[b]   <= r_s2[b];
          r_dcnt[b] <= '0;
        end else begin
          r_dcnt[b] <= r_dcnt[b] + DBW'(1);
        end
        // counts cycles since the press so repeats land on multiples
        if (!r_db[b] || w_both) begin
          r_rep[b] <= '0;
        end else if (r_rep[b] == REP_MAX) begin
          r_rep[b] <= RPW'(1);
        end else begin
          r_rep[b] <= r_rep[b] + RPW'(1);
        end
      end
    end
  end

  always_comb begin
    w_step = '0;
    for (int b = 0; b < 2; b++) begin
      w_step[b] = !w_both && r_db[b] &&
                  (!r_db_d[b] || r_rep[b] == REP_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        r_sp[i] <= SPDEF;
      end
    end else if (mode_switch && w_sel_ok) begin
      if (w_step[0] && r_sp[zone_sel] < SPMAX) begin
        r_sp[zone_sel] <= r_sp[zone_sel] + TEMP_W'(1);
      end else if (w_step[1] && r_sp[zone_sel] > SPMIN) begin
        r_sp[zone_sel] <= r_sp[zone_sel] - TEMP_W'(1);
      end
    end
  end

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      w_acc[i] = temp_valid && w_zone_ok && (temp_zone == ZW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        r_temp[i]  <= '0;
        r_stale[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (w_acc[i]) begin
          r_temp[i]  <= temp_in;
          r_stale[i] <= '0;
        end else if (r_stale[i] != ST_MAX) begin
          r_stale[i] <= r_stale[i] + STW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_cmp
    assign w_t[g] = {1'b0, r_temp[g]};
    assign w_s[g] = {1'b0, r_sp[g]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        r_st[i] <= S_FAULT;
      end
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        r_st[i] <= w_nx[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      w_nx[i] = r_st[i];
      unique case (r_st[i])
        S_FAULT: if (w_acc[i]) w_nx[i] = S_IDLE;
        S_IDLE: begin
          if (w_t[i] + HYS < w_s[i]) begin
            w_nx[i] = S_HEAT;
          end else if (w_t[i] > w_s[i] + HYS) begin
            w_nx[i] = S_COOL;
          end
        end
        S_HEAT: if (w_t[i] >= w_s[i]) w_nx[i] = S_IDLE;
        S_COOL: if (w_t[i] <= w_s[i]) w_nx[i] = S_IDLE;
        default: w_nx[i] = S_FAULT;
      endcase
      // a reading in the same cycle rescues the zone from going stale
      if (r_st[i] != S_FAULT && r_stale[i] == ST_MAX && !w_acc[i]) begin
        w_nx[i] = S_FAULT;
      end
    end
  end

  always_comb begin
    heat_on    = '0;
    cool_on    = '0;
    zone_fault = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      heat_on[i]    = (r_st[i] == S_HEAT);
      cool_on[i]    = (r_st[i] == S_COOL);
      zone_fault[i] = (r_st[i] == S_FAULT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_disp <= '0;
      r_lim  <= 1'b0;
    end else begin
      if (!w_sel_ok) begin
        r_disp <= '0;
      end else if (mode_switch) begin
        r_disp <= r_sp[zone_sel];
      end else begin
        r_disp <= r_temp[zone_sel];
      end
      r_lim <= w_sel_ok &&
               (r_sp[zone_sel] == SPMIN || r_sp[zone_sel] == SPMAX);
    end
  end

  assign display_temp = r_disp;
  assign sp_at_limit  = r_lim;

endmodule

// File: tb/tb_multi_zone_thermostat.sv
// Directed bench for multi_zone_thermostat with short debounce/repeat/stale
// timings; every expected value below is hand-computed.
module tb_multi_zone_thermostat;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       mode_switch = 1'b0;
  logic [1:0] zone_sel = '0;
  logic       temp_valid = 1'b0;
  logic [1:0] temp_zone = '0;
  logic [7:0] temp_in = '0;
  logic [7:0] display_temp;
  logic [3:0] heat_on;
  logic [3:0] cool_on;
  logic [3:0] zone_fault;
  logic       sp_at_limit;

  int n_cmp = 0;
  int n_err = 0;

  multi_zone_thermostat #(
    .NUM_ZONES(4),
    .TEMP_W(8),
    .HYST(1),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(16),
    .STALE_CYCLES(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .mode_switch(mode_switch),
    .zone_sel(zone_sel),
    .temp_valid(temp_valid),
    .temp_zone(temp_zone),
    .temp_in(temp_in),
    .display_temp(display_temp),
    .heat_on(heat_on),
    .cool_on(cool_on),
    .zone_fault(zone_fault),
    .sp_at_limit(sp_at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] z, input logic [7:0] t);
    temp_zone  = z;
    temp_in    = t;
    temp_valid = 1'b1;
    step(1);
    temp_valid = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_disp", display_temp, 0);
    chk("rst_fault", zone_fault, 4'hf);
    chk("rst_heat", heat_on, 0);
    chk("rst_cool", cool_on, 0);
    chk("rst_lim", sp_at_limit, 0);
    reset = 1'b1;
    step(1);

    mode_switch = 1'b0;
    zone_sel = 2'd2;
    strobe(2'd2, 8'd30);
    chk("z2_fault_clr", zone_fault[2], 0);
    step(1);
    chk("z2_disp30", display_temp, 30);
    chk("z2_cool", cool_on, 4'b0100);
    chk("z2_heat", heat_on, 0);

    mode_switch = 1'b1;
    zone_sel = 2'd0;
    step(2);
    chk("sp0_init", display_temp, 25);
    btn_up = 1'b1;
    step(3);
    btn_up = 1'b0;
    step(10);
    chk("up_short", display_temp, 25);
    btn_up = 1'b1;
    step(10);
    btn_up = 1'b0;
    chk("up_step", display_temp, 26);
    step(10);

    zone_sel = 2'd1;
    step(1);
    chk("sp1_init", display_temp, 25);
    btn_down = 1'b1;
    step(10);
    chk("dn_first", display_temp, 24);
    step(20);
    chk("dn_repeat", display_temp, 23);
    step(170);
    chk("dn_sat", display_temp, 16);
    chk("dn_lim", sp_at_limit, 1);
    btn_down = 1'b0;
    step(10);

    mode_switch = 1'b0;
    zone_sel = 2'd3;
    strobe(2'd3, 8'd23);
    step(1);
    chk("z3_heat23", heat_on[3], 1);
    strobe(2'd3, 8'd24);
    step(1);
    chk("z3_heat24", heat_on[3], 1);
    chk("z3_disp24", display_temp, 24);
    strobe(2'd3, 8'd25);
    step(1);
    chk("z3_idle_h", heat_on[3], 0);
    chk("z3_idle_c", cool_on[3], 0);
    strobe(2'd3, 8'd27);
    step(1);
    chk("z3_cool27", cool_on[3], 1);
    chk("z3_noheat", heat_on[3], 0);

    strobe(2'd2, 8'd30);
    step(1000);
    chk("z2_notstale", zone_fault[2], 0);
    chk("z2_cool_pre", cool_on[2], 1);
    step(1);
    chk("z2_stale", zone_fault[2], 1);
    chk("z2_cool_off", cool_on[2], 0);
    strobe(2'd2, 8'd25);
    chk("z2_recover", zone_fault[2], 0);
    step(1);
    chk("z2_idle_c", cool_on[2], 0);
    chk("z2_idle_h", heat_on[2], 0);

    mode_switch = 1'b1;
    zone_sel = 2'd0;
    step(2);
    chk("sp0_26", display_temp, 26);
    btn_up = 1'b1;
    btn_down = 1'b1;
    step(40);
    chk("both_held", display_temp, 26);
    btn_up = 1'b0;
    btn_down = 1'b0;
    step(10);
    chk("both_rel", display_temp, 26);
    btn_up = 1'b1;
    step(10);
    chk("up_27", display_temp, 27);
    reset = 1'b0;
    #1;
    chk("mid_rst_disp", display_temp, 0);
    chk("mid_rst_fault", zone_fault, 4'hf);
    chk("mid_rst_heat", heat_on, 0);
    step(2);
    reset = 1'b1;
    step(1);
    chk("post_rst_sp", display_temp, 25);
    step(3);
    chk("post_rst_nostep", display_temp, 25);
    step(6);
    chk("post_rst_edge", display_temp, 26);
    btn_up = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
